// File: rtl/result_reader.sv
// result_reader
// Reads NUM_WORDS result words from the synchronous result RAM, starting at
// BASE_ADDR, and streams them out on a valid/ready interface. A 2-entry
// prefetch FIFO keeps the stream at one word per cycle under back-pressure.
//
// State table:
//   IDLE | waiting for start
//   RUN  | issuing reads and streaming words
//   DONE | one-cycle completion pulse, then back to IDLE
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active low
//   start      - transfer request, sampled only in IDLE
//   rd_ram     - RAM read strobe
//   ram_addr   - RAM read address (driven 0 when rd_ram is low)
//   ram_rdata  - RAM read data, valid the cycle after rd_ram
//   out_data   - head word of the stream
//   out_valid  - out_data is valid
//   out_ready  - consumer accepts the head word
//   busy       - transfer in progress (RUN or DONE)
//   done       - one-cycle pulse after the last word is accepted
module result_reader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_ram,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  pop_cnt;
    logic              inflight;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_count;
    logic [1:0]        occ;
    logic              pop;
    logic              push;
    logic              last_pop;
    logic [ADDR_W-1:0] addr_cur;

    // occ counts words already owned by the buffer, including the one
    // still on its way out of the RAM; it can never exceed 2.
    assign occ       = fifo_count + {1'b0, inflight};
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push      = inflight;
    assign last_pop  = pop && (pop_cnt == CNT_W'(NUM_WORDS - 1));
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // A pop in this cycle frees a slot in time for the read issued now.
    assign rd_ram = (state == S_RUN)
                 && (issue_cnt < CNT_W'(NUM_WORDS))
                 && ((occ < 2'd2) || ((occ == 2'd2) && pop));

    // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap.
    assign addr_cur = ADDR_W'(BASE_ADDR) + ADDR_W'(issue_cnt);
    assign ram_addr = rd_ram ? addr_cur : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            issue_cnt <= '0;
            pop_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        issue_cnt <= '0;
                        pop_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    if (rd_ram) issue_cnt <= issue_cnt + CNT_W'(1);
                    if (pop)    pop_cnt   <= pop_cnt + CNT_W'(1);
                    if (last_pop) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reset clears inflight, so read data already on its way is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight    <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            inflight <= rd_ram;
            if (push) begin
                fifo_mem[wr_ptr] <= ram_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader. Three instances with different geometry share one
// clock, reset and RAM image:
//   0: NUM_WORDS=8, BASE_ADDR=0
//   1: NUM_WORDS=4, BASE_ADDR=14 (address wrap)
//   2: NUM_WORDS=1, BASE_ADDR=0
// The reference model tracks reads issued, words delivered and words that
// have arrived from RAM, and derives every expected output from those counts.
module tb_result_reader;

    logic        clk;
    logic        rst;
    logic        start_v [3];
    logic        rd_v    [3];
    logic [3:0]  addr_v  [3];
    logic [31:0] rdata_v [3];
    logic [31:0] odata_v [3];
    logic        valid_v [3];
    logic        rdy_v   [3];
    logic        busy_v  [3];
    logic        done_v  [3];

    logic [31:0] ram [16];
    int          base_p [3] = '{0, 14, 0};
    int          num_p  [3] = '{8, 4, 1};

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        for (int k = 0; k < 3; k++)
            if (rd_v[k] === 1'b1) rdata_v[k] <= ram[addr_v[k]];

    result_reader #(.DATA_W(32), .ADDR_W(4), .NUM_WORDS(8), .BASE_ADDR(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .rd_ram(rd_v[0]),
        .ram_addr(addr_v[0]), .ram_rdata(rdata_v[0]), .out_data(odata_v[0]),
        .out_valid(valid_v[0]), .out_ready(rdy_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    result_reader #(.DATA_W(32), .ADDR_W(4), .NUM_WORDS(4), .BASE_ADDR(14)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .rd_ram(rd_v[1]),
        .ram_addr(addr_v[1]), .ram_rdata(rdata_v[1]), .out_data(odata_v[1]),
        .out_valid(valid_v[1]), .out_ready(rdy_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    result_reader #(.DATA_W(32), .ADDR_W(4), .NUM_WORDS(1), .BASE_ADDR(0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .rd_ram(rd_v[2]),
        .ram_addr(addr_v[2]), .ram_rdata(rdata_v[2]), .out_data(odata_v[2]),
        .out_valid(valid_v[2]), .out_ready(rdy_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // mode 0: always ready, 1: stalled until t=20, 2: alternating, 3: random
    function automatic logic rdy_f(input int mode, input int t);
        case (mode)
            0:       return 1'b1;
            1:       return (t > 20);
            2:       return ((t % 2) == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Runs nx back-to-back transfers on instance k (start held when nx > 1).
    // t counts cycles from the IDLE cycle in which start is accepted.
    task automatic xfer(input int k, input int mode, input int nx);
        int n, base, c, t0, t, reads, pops, last_pop, rp1, rp2, xdone, occ;
        logic pop_now, exp_rd, exp_v, phold;
        logic [31:0] pdata;
        n = num_p[k];
        base = base_p[k];
        reads = 0; pops = 0; last_pop = -10; rp1 = 0; rp2 = 0;
        xdone = 0; t0 = 0; phold = 1'b0; pdata = '0;
        @(posedge clk); #1;
        start_v[k] = 1'b1;
        rdy_v[k]   = rdy_f(mode, 0);
        for (c = 0; c < 400 && xdone < nx; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (nx == 1) start_v[k] = 1'b0;
                rdy_v[k] = rdy_f(mode, c - t0);
            end
            @(negedge clk);
            t = c - t0;
            // a word read in cycle x is in the buffer from cycle x+2
            exp_v = (rp2 > pops);
            chk("busy", 32'(busy_v[k]), 32'(t >= 1));
            chk("done", 32'(done_v[k]), 32'(pops == n && last_pop == c - 1));
            chk("out_valid", 32'(valid_v[k]), 32'(exp_v));
            if (exp_v) chk("out_data", odata_v[k], ram[(base + pops) % 16]);
            if (phold) chk("hold_data", odata_v[k], pdata);
            pop_now = exp_v && rdy_v[k];
            occ = reads - pops;
            exp_rd = (t >= 1) && (reads < n) && (occ < 2 || pop_now);
            chk("rd_ram", 32'(rd_v[k]), 32'(exp_rd));
            if (rd_v[k] === 1'b1) begin
                chk("ram_addr", 32'(addr_v[k]), 32'((base + reads) % 16));
                reads++;
                if (mode == 0) chk("stream_rd_cycle", 32'(t), 32'(reads));
            end
            if (mode == 0 && pop_now) chk("stream_pop_cycle", 32'(t), 32'(pops + 3));
            if (mode == 0 && done_v[k] === 1'b1) chk("stream_done_cycle", 32'(t), 32'(n + 3));
            if (mode == 1 && t == 20) begin
                chk("bp_reads", 32'(reads), 32'd2);
                chk("bp_valid", 32'(valid_v[k]), 32'd1);
                chk("bp_data", odata_v[k], ram[base % 16]);
            end
            phold = exp_v && !rdy_v[k];
            pdata = odata_v[k];
            if (pop_now) begin
                pops++;
                last_pop = c;
            end
            rp2 = rp1;
            rp1 = reads;
            if (done_v[k] === 1'b1) begin
                xdone++;
                t0 = c + 1;
                reads = 0; pops = 0; rp1 = 0; rp2 = 0; last_pop = -10; phold = 1'b0;
            end
        end
        chk("transfers_done", 32'(xdone), 32'(nx));
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        rdy_v[k]   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input int k);
        chk("rst_rd_ram",    32'(rd_v[k]),    32'd0);
        chk("rst_ram_addr",  32'(addr_v[k]),  32'd0);
        chk("rst_out_valid", 32'(valid_v[k]), 32'd0);
        chk("rst_out_data",  odata_v[k],      32'd0);
        chk("rst_busy",      32'(busy_v[k]),  32'd0);
        chk("rst_done",      32'(done_v[k]),  32'd0);
    endtask

    task automatic reset_mid();
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        rdy_v[0]   = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            start_v[0] = 1'b0;
        end
        chk("mid_busy_before_rst", 32'(busy_v[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_outputs(0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) ram[i] = $urandom;
        xfer(0, 3, 1);
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            rdy_v[k]   = 1'b0;
        end
        for (int i = 0; i < 16; i++) ram[i] = 32'h1111_0000 + 32'(i);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_reset_outputs(k);
        rst = 1'b1;

        xfer(0, 0, 1);
        xfer(0, 1, 1);
        xfer(0, 2, 1);
        for (int i = 0; i < 16; i++) ram[i] = $urandom;
        xfer(0, 3, 1);
        xfer(0, 3, 1);
        xfer(1, 0, 1);
        xfer(1, 3, 3);
        xfer(2, 3, 4);
        xfer(2, 0, 2);
        reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
